// File: rtl/ahblite_busmatrix_inputstage_sys.sv
// ahblite_busmatrix_inputstage_sys: SYS master input stage with SUB decode, address hold and default ERROR subordinate.
// Define INPUTSTAGE_BYPASS_EN to pass granted transfers straight through instead of always registering them.
module ahblite_busmatrix_inputstage_sys #(
    parameter logic [31:0] SUB_BASE = 32'h0000_0000,
    parameter logic [31:0] SUB_MASK = 32'hE000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL_SYS,
    input  logic [31:0] HADDR_SYS,
    input  logic [1:0]  HTRANS_SYS,
    input  logic        HWRITE_SYS,
    input  logic [2:0]  HSIZE_SYS,
    input  logic [2:0]  HBURST_SYS,
    input  logic [3:0]  HPROT_SYS,
    input  logic        HREADY_SYS,
    output logic        HREADYOUT_SYS,
    output logic        HRESP_SYS,
    input  logic        ACTIVE_Outputstage_SUB,
    input  logic        HREADY_Outputstage_SUB,
    input  logic        HREADYOUT_Outputstage_SUB,
    input  logic        HRESP_Outputstage_SUB,
    output logic        REQ_SYS,
    output logic        HSEL_Inputstage_SYS,
    output logic [31:0] HADDR_Inputstage_SYS,
    output logic [1:0]  HTRANS_Inputstage_SYS,
    output logic        HWRITE_Inputstage_SYS,
    output logic [2:0]  HSIZE_Inputstage_SYS,
    output logic [2:0]  HBURST_Inputstage_SYS,
    output logic [3:0]  HPROT_Inputstage_SYS
);
    typedef enum logic [1:0] {DEF_IDLE, DEF_ERR1, DEF_ERR2} def_t;
    def_t        def_q, def_d;
    logic        pend, dphase_sub;
    logic [31:0] h_addr;
    logic [1:0]  h_trans;
    logic        h_write;
    logic [2:0]  h_size, h_burst;
    logic [3:0]  h_prot;
    logic        live, hit, accept, sub_live, capture, launch, seq;

    assign live     = HSEL_SYS & HREADY_SYS & HTRANS_SYS[1];
    assign hit      = (HADDR_SYS & SUB_MASK) == SUB_BASE;
    assign accept   = ACTIVE_Outputstage_SUB & HREADY_Outputstage_SUB;
    assign sub_live = live & hit & ~pend;
    assign seq      = HTRANS_SYS == 2'b11;
    assign REQ_SYS  = pend | (live & hit);

`ifdef INPUTSTAGE_BYPASS_EN
    assign capture               = sub_live & ~accept;
    assign launch                = (pend | sub_live) & accept;
    assign HSEL_Inputstage_SYS   = pend | (HSEL_SYS & hit);
    assign HADDR_Inputstage_SYS  = pend ? h_addr : HADDR_SYS;
    assign HTRANS_Inputstage_SYS = pend ? h_trans : (HSEL_SYS & hit & HREADY_SYS) ? HTRANS_SYS : 2'b00;
    assign HWRITE_Inputstage_SYS = pend ? h_write : HWRITE_SYS;
    assign HSIZE_Inputstage_SYS  = pend ? h_size : HSIZE_SYS;
    assign HBURST_Inputstage_SYS = pend ? h_burst : HBURST_SYS;
    assign HPROT_Inputstage_SYS  = pend ? h_prot : HPROT_SYS;
`else
    assign capture               = sub_live;
    assign launch                = pend & accept;
    assign HSEL_Inputstage_SYS   = pend;
    assign HADDR_Inputstage_SYS  = h_addr;
    assign HTRANS_Inputstage_SYS = pend ? h_trans : 2'b00;
    assign HWRITE_Inputstage_SYS = h_write;
    assign HSIZE_Inputstage_SYS  = h_size;
    assign HBURST_Inputstage_SYS = h_burst;
    assign HPROT_Inputstage_SYS  = h_prot;
`endif

    // A held SEQ may follow a lost grant, so it restarts as NONSEQ INCR.
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            def_q      <= DEF_IDLE;
            pend       <= 1'b0;
            dphase_sub <= 1'b0;
            h_addr     <= '0;
            h_trans    <= '0;
            h_write    <= 1'b0;
            h_size     <= '0;
            h_burst    <= '0;
            h_prot     <= '0;
        end else begin
            def_q      <= def_d;
            pend       <= capture | (pend & ~accept);
            dphase_sub <= launch | (dphase_sub & ~HREADYOUT_Outputstage_SUB);
            if (capture) begin
                h_addr  <= HADDR_SYS;
                h_trans <= seq ? 2'b10 : HTRANS_SYS;
                h_write <= HWRITE_SYS;
                h_size  <= HSIZE_SYS;
                h_burst <= seq ? 3'b001 : HBURST_SYS;
                h_prot  <= HPROT_SYS;
            end
        end

    always_comb begin
        def_d         = DEF_IDLE;
        HREADYOUT_SYS = 1'b1;
        HRESP_SYS     = 1'b0;
        def_d         = (def_q == DEF_ERR1) ? DEF_ERR2 : (live & ~hit) ? DEF_ERR1 : DEF_IDLE;
        HREADYOUT_SYS = pend ? 1'b0 : (def_q == DEF_ERR1) ? 1'b0 : (def_q == DEF_ERR2) ? 1'b1 :
                        dphase_sub ? HREADYOUT_Outputstage_SUB : 1'b1;
        HRESP_SYS     = pend ? 1'b0 : (def_q != DEF_IDLE) ? 1'b1 : dphase_sub ? HRESP_Outputstage_SUB : 1'b0;
    end
endmodule
